ad9231_spi_cfg_sequencer: RTL and testbench

- Table-driven configuration controller for the AD9231 SPI master. On auto-start after reset, or on a `cfg_start` pulse, it performs three phases:
  - writes every register in a constant table;
  - issues the AD9231 transfer command (reg 0xFF = 0x01);
  - reads back every verify-enabled entry and compares it.
- It retries mismatching entries, times out on a stuck SPI master, and reports done/error status to the system controller.
- It sits between the ADC front-end control logic and the existing SPI master, which uses a start/done handshake.

---
 rtl/ad9231_cfg_pkg.sv | 55 +++++
 rtl/ad9231_spi_cfg_sequencer_rom.sv | 28 ++
 rtl/ad9231_spi_cfg_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ad9231_spi_cfg_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9231_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad9231_cfg_pkg
//  Description : Shared types and constants for the AD9231 SPI configuration
//                sequencer: FSM state encoding, error codes, transfer-command
//                constants and the 22-bit table entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad9231_cfg_pkg;

    // Sequencer states; explicit 4-bit encoding
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ISSUE = 4'd1,
        ST_WR_WAIT  = 4'd2,
        ST_XF_ISSUE = 4'd3,
        ST_XF_WAIT  = 4'd4,
        ST_RD_ISSUE = 4'd5,
        ST_RD_WAIT  = 4'd6,
        ST_CHECK    = 4'd7,
        ST_DONE     = 4'd8,
        ST_FAIL     = 4'd9
    } cfg_state_t;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    // AD9231 "transfer" register: writing 0x01 to 0xFF commits shadow regs
    localparam logic [12:0] XFER_ADDR = 13'h0FF;
    localparam logic [7:0]  XFER_DATA = 8'h01;

    // Table entry layout {vfy[21], addr[20:8], data[7:0]}
    localparam int ENTRY_W = 22;

    typedef struct packed {
        logic        vfy;
        logic [12:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    // Builds one table entry from its fields
    function automatic cfg_entry_t make_entry(input logic        vfy,
                                              input logic [12:0] addr,
                                              input logic [7:0]  data);
        cfg_entry_t e;
        e.vfy  = vfy;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9231_spi_cfg_sequencer_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ad9231_cfg_rom
//  Description : Constant configuration table. Combinational idx -> entry
//                lookup; unused indices return an all-zero (vfy=0) entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9231_cfg_rom
    import ad9231_cfg_pkg::*;
(
    input  logic [3:0]         idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    // Table contents: register address, value and whether it is read back
    always_comb begin
        entry_o = '0;
        case (idx_i)
            4'd0:    entry_o = make_entry(1'b1, 13'h014, 8'h20);
            4'd1:    entry_o = make_entry(1'b1, 13'h00D, 8'h00);
            4'd2:    entry_o = make_entry(1'b1, 13'h008, 8'h00);
            4'd3:    entry_o = make_entry(1'b0, 13'h016, 8'h00);
            default: entry_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ad9231_spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ad9231_spi_cfg_sequencer
//  Description : Table-driven AD9231 configuration controller. Writes every
//                table entry, issues the transfer command, then reads back
//                and verifies flagged entries with bounded retries and a
//                per-command SPI timeout. Drives an SPI master through a
//                start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9231_spi_cfg_sequencer
    import ad9231_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int AUTO_START  = 1
) (
    input  logic        clk_200m,
    input  logic        rst,
    input  logic        cfg_start,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [1:0]  err_code,
    output logic [3:0]  err_index,
    output logic [12:0] spi_addr,
    output logic [7:0]  spi_data,
    output logic        spi_rw,
    output logic [1:0]  spi_len,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata
);

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    cfg_state_t         state_q;
    logic [3:0]         idx_q;
    logic [3:0]         retry_cnt_q;
    logic               retry_mode_q;
    logic [15:0]        timer_q;
    logic               boot_q;       // high only on the first post-reset cycle
    logic [7:0]         rdata_q;
    logic               cfg_busy_q;
    logic               cfg_done_q;
    logic               cfg_err_q;
    logic [1:0]         err_code_q;
    logic [3:0]         err_index_q;
    logic [12:0]        spi_addr_q;
    logic [7:0]         spi_data_q;
    logic               spi_rw_q;
    logic               spi_start_q;

    logic [ENTRY_W-1:0] rom_bits;
    cfg_entry_t         entry;

    ad9231_cfg_rom u_rom (
        .idx_i   (idx_q),
        .entry_o (rom_bits)
    );

    assign entry = cfg_entry_t'(rom_bits);

    // Sequencer FSM; all outputs registered and updated on state entry
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            retry_cnt_q  <= '0;
            retry_mode_q <= 1'b0;
            timer_q      <= '0;
            boot_q       <= 1'b1;
            rdata_q      <= '0;
            cfg_busy_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_index_q  <= '0;
            spi_addr_q   <= '0;
            spi_data_q   <= '0;
            spi_rw_q     <= 1'b0;
            spi_start_q  <= 1'b0;
        end else begin
            boot_q      <= 1'b0;
            spi_start_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start || ((AUTO_START != 0) && boot_q)) begin
                        state_q      <= ST_WR_ISSUE;
                        idx_q        <= '0;
                        retry_cnt_q  <= '0;
                        retry_mode_q <= 1'b0;
                        cfg_busy_q   <= 1'b1;
                        cfg_err_q    <= 1'b0;
                        err_code_q   <= ERR_NONE;
                        err_index_q  <= '0;
                    end
                end
                ST_WR_ISSUE: begin
                    spi_addr_q  <= entry.addr;
                    spi_data_q  <= entry.data;
                    spi_rw_q    <= 1'b0;
                    spi_start_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= ST_WR_WAIT;
                end
                ST_XF_ISSUE: begin
                    spi_addr_q  <= XFER_ADDR;
                    spi_data_q  <= XFER_DATA;
                    spi_rw_q    <= 1'b0;
                    spi_start_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= ST_XF_WAIT;
                end
                ST_RD_ISSUE: begin
                    if (!entry.vfy) begin
                        // Unverified entry: skip without touching the SPI bus
                        if (idx_q == LAST_IDX) begin
                            state_q    <= ST_DONE;
                            cfg_done_q <= 1'b1;
                            cfg_busy_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else begin
                        spi_addr_q  <= entry.addr;
                        spi_data_q  <= '0;
                        spi_rw_q    <= 1'b1;
                        spi_start_q <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= ST_RD_WAIT;
                    end
                end
                ST_WR_WAIT, ST_XF_WAIT, ST_RD_WAIT: begin
                    if (spi_done) begin
                        if (state_q == ST_WR_WAIT) begin
                            // A retry rewrites only the failing entry
                            if (retry_mode_q || (idx_q == LAST_IDX)) begin
                                state_q <= ST_XF_ISSUE;
                            end else begin
                                idx_q   <= idx_q + 4'd1;
                                state_q <= ST_WR_ISSUE;
                            end
                        end else if (state_q == ST_XF_WAIT) begin
                            if (!retry_mode_q) begin
                                idx_q <= '0;
                            end
                            state_q <= ST_RD_ISSUE;
                        end else begin
                            rdata_q <= spi_rdata;
                            state_q <= ST_CHECK;
                        end
                    end else if (timer_q == TMO_LAST) begin
                        state_q     <= ST_FAIL;
                        cfg_busy_q  <= 1'b0;
                        cfg_err_q   <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        err_index_q <= idx_q;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (rdata_q == entry.data) begin
                        retry_cnt_q  <= '0;
                        retry_mode_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q    <= ST_DONE;
                            cfg_done_q <= 1'b1;
                            cfg_busy_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= ST_RD_ISSUE;
                        end
                    end else if (retry_cnt_q < RETRY_LIM) begin
                        retry_cnt_q  <= retry_cnt_q + 4'd1;
                        retry_mode_q <= 1'b1;
                        state_q      <= ST_WR_ISSUE;
                    end else begin
                        state_q     <= ST_FAIL;
                        cfg_busy_q  <= 1'b0;
                        cfg_err_q   <= 1'b1;
                        err_code_q  <= ERR_MISMATCH;
                        err_index_q <= idx_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_FAIL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cfg_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_busy  = cfg_busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;
    assign spi_addr  = spi_addr_q;
    assign spi_data  = spi_data_q;
    assign spi_rw    = spi_rw_q;
    assign spi_len   = 2'b00;
    assign spi_start = spi_start_q;

endmodule
`default_nettype wire

// File: tb/tb_ad9231_spi_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ad9231_spi_cfg_sequencer
//  Description : Self-checking bench: SPI slave model with register echo,
//                programmable bad readbacks, hang and double-done behaviour,
//                plus a command-list reference model of the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9231_spi_cfg_sequencer;

    localparam int NUM_REGS    = 4;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 100;

    typedef struct packed {
        logic        rw;
        logic [12:0] addr;
        logic [7:0]  data;
    } cmd_t;

    logic        clk_200m  = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_start = 1'b0;
    logic        spi_done  = 1'b0;
    logic [7:0]  spi_rdata = 8'h00;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [1:0]  err_code;
    logic [3:0]  err_index;
    logic [12:0] spi_addr;
    logic [7:0]  spi_data;
    logic        spi_rw;
    logic [1:0]  spi_len;
    logic        spi_start;

    int n_checks = 0;
    int n_errors = 0;

    // Bench copy of the configuration table
    logic [12:0] t_addr [NUM_REGS] = '{13'h014, 13'h00D, 13'h008, 13'h016};
    logic [7:0]  t_data [NUM_REGS] = '{8'h20, 8'h00, 8'h00, 8'h00};
    logic        t_vfy  [NUM_REGS] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Slave model configuration and state
    cmd_t       cmd_log [$];
    cmd_t       exp_q   [$];
    int         bad_left  = 0;
    logic [7:0] bad_val   = 8'h00;
    bit         hang_wr   = 1'b0;
    bit         dbl_en    = 1'b0;
    int         fixed_lat = 0;
    int         pending   = 0;
    bit         pend_dbl  = 1'b0;
    logic [7:0] resp      = 8'h00;
    logic [7:0] mem [0:8191];

    ad9231_spi_cfg_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .AUTO_START  (1)
    ) dut (
        .clk_200m  (clk_200m),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_code  (err_code),
        .err_index (err_index),
        .spi_addr  (spi_addr),
        .spi_data  (spi_data),
        .spi_rw    (spi_rw),
        .spi_len   (spi_len),
        .spi_start (spi_start),
        .spi_done  (spi_done),
        .spi_rdata (spi_rdata)
    );

    always #2.5 clk_200m = ~clk_200m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic rw, input logic [12:0] a, input logic [7:0] d);
        cmd_t c;
        c.rw   = rw;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    function automatic int pick_lat();
        if (fixed_lat > 0) return fixed_lat;
        return int'($urandom_range(1, 30));
    endfunction

    // Expected command list: write all, transfer, then read/verify with
    // rewrite+transfer+reread on mismatch; reg 0x014 reads bad k times
    function automatic void build_expected(input int k, output bit f, output logic [3:0] fidx);
        int reads14;
        int tries;
        bit ok;
        exp_q.delete();
        f = 1'b0;
        fidx = 4'd0;
        reads14 = 0;
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(mk_cmd(1'b0, t_addr[i], t_data[i]));
        exp_q.push_back(mk_cmd(1'b0, 13'h0FF, 8'h01));
        for (int i = 0; i < NUM_REGS && !f; i++) begin
            if (t_vfy[i]) begin
                tries = 0;
                ok = 1'b0;
                while (!ok && !f) begin
                    exp_q.push_back(mk_cmd(1'b1, t_addr[i], 8'h00));
                    if (t_addr[i] == 13'h014 && reads14 < k) reads14++;
                    else ok = 1'b1;
                    if (!ok) begin
                        if (tries == MAX_RETRY) begin
                            f = 1'b1;
                            fidx = 4'(i);
                        end else begin
                            tries++;
                            exp_q.push_back(mk_cmd(1'b0, t_addr[i], t_data[i]));
                            exp_q.push_back(mk_cmd(1'b0, 13'h0FF, 8'h01));
                        end
                    end
                end
            end
        end
    endfunction

    // SPI slave: logs commands, echoes writes, answers after a latency
    initial begin
        forever begin
            @(negedge clk_200m);
            spi_done = 1'b0;
            if (rst) begin
                pending  = 0;
                pend_dbl = 1'b0;
            end else begin
                if (pend_dbl) begin
                    spi_done = 1'b1;
                    pend_dbl = 1'b0;
                end
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        spi_done  = 1'b1;
                        spi_rdata = resp;
                        pend_dbl  = dbl_en;
                    end
                end
                if (spi_start) begin
                    cmd_log.push_back(mk_cmd(spi_rw, spi_addr, spi_data));
                    if (!spi_rw) begin
                        mem[spi_addr] = spi_data;
                        resp = 8'h00;
                        if (hang_wr) hang_wr = 1'b0;
                        else pending = pick_lat();
                    end else begin
                        if (spi_addr == 13'h014 && bad_left > 0) begin
                            resp = bad_val;
                            bad_left--;
                        end else begin
                            resp = mem[spi_addr];
                        end
                        pending = pick_lat();
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".ctl"}, {28'd0, cfg_busy, cfg_done, cfg_err, spi_start}, 32'd0);
        check_eq({tag, ".err"}, {26'd0, err_code, err_index}, 32'd0);
        check_eq({tag, ".spi"}, {8'd0, spi_addr, spi_data, spi_rw, spi_len}, 32'd0);
    endtask

    task automatic run_seq(input string tag, input bit use_start, input int k,
                           input logic [7:0] bv, input bit hang, input bit dbl,
                           input bit inject, input int lat);
        bit exp_fail;
        logic [3:0] exp_idx;
        int cyc, fin_cyc, start_cyc, err_cyc, n_done, n_cmp;
        bit fin, got_busy;
        bad_left  = k;
        bad_val   = bv;
        hang_wr   = hang;
        dbl_en    = dbl;
        fixed_lat = lat;
        cmd_log.delete();
        build_expected(k, exp_fail, exp_idx);
        if (hang) begin
            exp_q.delete();
            exp_q.push_back(mk_cmd(1'b0, t_addr[0], t_data[0]));
            exp_fail = 1'b1;
            exp_idx  = 4'd0;
        end
        if (use_start) begin
            @(negedge clk_200m);
            cfg_start = 1'b1;
            @(negedge clk_200m);
            cfg_start = 1'b0;
        end
        got_busy = 1'b0;
        for (int i = 0; i < 10 && !got_busy; i++) begin
            if (cfg_busy) got_busy = 1'b1;
            else @(negedge clk_200m);
        end
        check_eq({tag, ".busy_rise"}, 32'(got_busy), 32'd1);
        check_eq({tag, ".err_clr"}, {30'd0, err_code, cfg_err} == 32'd0 ? 32'd0 : 32'd1, 32'd0);
        fin = 1'b0; n_done = 0; start_cyc = -1; err_cyc = -1; cyc = 0; fin_cyc = 0;
        while (cyc < 20000 && !(fin && cyc >= fin_cyc + 20)) begin
            @(negedge clk_200m);
            cyc++;
            cfg_start = 1'b0;
            if (spi_start && start_cyc < 0) start_cyc = cyc;
            if (cfg_done) n_done++;
            if (cfg_err && err_cyc < 0) err_cyc = cyc;
            if (!fin && (cfg_done || cfg_err)) begin
                fin = 1'b1;
                fin_cyc = cyc;
            end
            if (inject && cfg_busy && $urandom_range(0, 15) == 0) cfg_start = 1'b1;
        end
        cfg_start = 1'b0;
        check_eq({tag, ".finished"}, 32'(fin), 32'd1);
        check_eq({tag, ".done_cnt"}, 32'(n_done), exp_fail ? 32'd0 : 32'd1);
        check_eq({tag, ".cfg_err"}, 32'(cfg_err), 32'(exp_fail));
        check_eq({tag, ".err_code"}, 32'(err_code), exp_fail ? (hang ? 32'd1 : 32'd2) : 32'd0);
        check_eq({tag, ".err_index"}, 32'(err_index), exp_fail ? 32'(exp_idx) : 32'd0);
        check_eq({tag, ".busy_end"}, 32'(cfg_busy), 32'd0);
        check_eq({tag, ".spi_len"}, 32'(spi_len), 32'd0);
        if (hang) check_eq({tag, ".tmo_cycles"}, 32'(err_cyc - start_cyc), 32'(TIMEOUT_CYC));
        check_eq({tag, ".n_cmds"}, 32'(cmd_log.size()), 32'(exp_q.size()));
        n_cmp = (cmd_log.size() < exp_q.size()) ? cmd_log.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) check_eq({tag, ".cmd"}, 32'(cmd_log[i]), 32'(exp_q[i]));
    endtask

    task automatic reset_mid_read();
        bit seen;
        seen      = 1'b0;
        bad_left  = 0;
        hang_wr   = 1'b0;
        dbl_en    = 1'b0;
        fixed_lat = 40;
        @(negedge clk_200m);
        cfg_start = 1'b1;
        @(negedge clk_200m);
        cfg_start = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk_200m);
            if (spi_start && spi_rw) seen = 1'b1;
        end
        check_eq("rst.rd_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clk_200m);
        rst = 1'b1;
        @(negedge clk_200m);
        check_all_zero("rst_mid");
        @(negedge clk_200m);
        rst = 1'b0;
        run_seq("rst_restart", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bv;
        int k;
        repeat (4) @(negedge clk_200m);
        check_all_zero("reset");
        rst = 1'b0;
        run_seq("auto", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 40);
        run_seq("retry2", 1'b1, 2, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        run_seq("fail", 1'b1, 255, 8'h21, 1'b0, 1'b0, 1'b0, 0);
        run_seq("tmo", 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        run_seq("tmo_rerun", 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        reset_mid_read();
        run_seq("spur", 1'b1, 1, 8'h00, 1'b0, 1'b1, 1'b1, 0);
        for (int r = 0; r < 5; r++) begin
            k  = int'($urandom_range(0, 3));
            bv = 8'($urandom_range(0, 255));
            if (bv == 8'h20) bv = 8'h5A;
            run_seq("rand", 1'b1, k, bv, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
